// File: rtl/ram_rmw_ctrl_pkg.sv
// ram_rmw_pkg: op and FSM state encodings shared by the read-modify-write RAM controller.
package ram_rmw_pkg;
    localparam logic [1:0] OP_ENC_READ  = 2'b00;
    localparam logic [1:0] OP_ENC_WRITE = 2'b01;
    localparam logic [1:0] OP_ENC_ADD   = 2'b10;
    localparam logic [1:0] OP_ENC_SWAP  = 2'b11;
    typedef enum logic [1:0] {
        OP_READ  = OP_ENC_READ,
        OP_WRITE = OP_ENC_WRITE,
        OP_ADD   = OP_ENC_ADD,
        OP_SWAP  = OP_ENC_SWAP
    } op_e;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_CLEAR   = 2'd2;
    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RD_WAIT = ST_RD_WAIT,
        CLEAR   = ST_CLEAR
    } state_e;
endpackage

// File: rtl/ram_rmw_ctrl_sync_ram_sp.sv
// sync_ram_sp: single-port RAM, write on wen, registered read of the old word (1-cycle latency).
module sync_ram_sp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (wen) mem[addr] <= wdata;
        q <= mem[addr];
    end
endmodule

// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl: one-request-at-a-time READ/WRITE/ADD/SWAP controller around a single-port RAM.
// Define RAM_RMW_CTRL_MEM_CLEAR_EN to zero the whole array after every reset.
module ram_rmw_ctrl
    import ram_rmw_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);
`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
    localparam state_e RST_ST = CLEAR;
`else
    localparam state_e RST_ST = IDLE;
`endif
    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q, clr_addr, ram_addr;
    logic [DATA_W-1:0] data_q, wdata, q, sum;
    logic              err_q, wen, in_range, idle, rd_wait, accept, wr_acc;

    assign idle      = state == IDLE;
    assign rd_wait   = state == RD_WAIT;
    assign req_ready = idle;
    assign busy      = ~idle;
    assign accept    = req_valid && idle;
    assign wr_acc    = accept && op_e'(req_op) == OP_WRITE;
    assign in_range  = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
    assign sum       = q + data_q;

    // reset gates wen so an abandoned RMW never lands in the array
    always_comb begin
        ram_addr = idle ? req_addr : rd_wait ? addr_q : clr_addr;
        wdata    = idle ? req_data : rd_wait ? (op_q == OP_ADD ? sum : data_q) : '0;
        wen      = !reset && (idle ? wr_acc && in_range
                            : rd_wait ? (op_q == OP_ADD || op_q == OP_SWAP) && !err_q
                            : state == CLEAR);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= RST_ST;
        else if (accept && !wr_acc) state <= RD_WAIT;
        else if (rd_wait) state <= IDLE;
`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
        else if (state == CLEAR && clr_addr == ADDR_W'(DEPTH-1)) state <= IDLE;
`endif
    end

`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
    always_ff @(posedge clock) clr_addr <= (reset || state != CLEAR) ? '0 : clr_addr + 1'b1;
`else
    assign clr_addr = '0;
`endif

    always_ff @(posedge clock) begin
        if (idle) begin
            op_q   <= op_e'(req_op);
            addr_q <= req_addr;
            data_q <= req_data;
            err_q  <= !in_range;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= wr_acc || rd_wait;
            rsp_err   <= wr_acc ? !in_range : rd_wait && err_q;
            rsp_data  <= wr_acc ? (in_range ? req_data : '0)
                       : (rd_wait && !err_q) ? (op_q == OP_ADD ? sum : q) : '0;
        end
    end

    sync_ram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
        .clock(clock),
        .addr (ram_addr),
        .wdata(wdata),
        .wen  (wen),
        .q    (q)
    );
endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// tb_ram_rmw_ctrl: directed and random requests checked against a transaction-level memory model.
// Honours RAM_RMW_CTRL_MEM_CLEAR_EN (DEPTH 16, cleared memory) like the design.
module tb_ram_rmw_ctrl;
`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 200;
`endif
    typedef struct {int due; logic [7:0] d; logic e;} exp_t;

    logic clk = 0, reset = 1, req_valid = 0, req_ready, rsp_valid, rsp_err, busy;
    logic [1:0] req_op = 0;
    logic [7:0] req_addr = 0, req_data = 0, rsp_data;

    logic [7:0] mem_m [DEPTH];
    exp_t expq[$];
    int cyc = 0, rd_busy_p = -1, clr_s = 1, clr_e = 0, errs = 0, checks = 0;
    bit chk_en = 0, acc = 0, pend = 0;
    logic [7:0] pend_a, pend_v;

    ram_rmw_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH)) dut (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", n, cyc, a, e);
        end
    endtask

    function automatic bit m_ready(int p);
        return p != rd_busy_p && !(p >= clr_s && p <= clr_e);
    endfunction

    // Advance one edge and apply to the model whatever that edge did.
    task automatic tick();
        int a;
        bit ok;
        logic [7:0] old, nv;
        @(posedge clk);
        #1;
        acc = 0;
        if (reset) begin
            expq.delete();
            pend = 0;
            rd_busy_p = -1;
`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
            clr_s = cyc;
            clr_e = cyc + DEPTH - 1;
            foreach (mem_m[i]) mem_m[i] = 8'h00;
`endif
        end else begin
            if (pend) begin mem_m[pend_a] = pend_v; pend = 0; end
            acc = req_valid && m_ready(cyc - 1);
            if (acc) begin
                a = int'(req_addr);
                ok = a < DEPTH;
                old = ok ? mem_m[a] : 8'h00;
                if (req_op == 2'b01) begin
                    if (ok) mem_m[a] = req_data;
                    expq.push_back(exp_t'{cyc, ok ? req_data : 8'h00, !ok});
                end else begin
                    rd_busy_p = cyc;
                    nv = (req_op == 2'b10) ? old + req_data : req_data;
                    expq.push_back(exp_t'{cyc + 1, !ok ? 8'h00 : (req_op == 2'b10) ? nv : old, !ok});
                    if (ok && req_op != 2'b00) begin pend = 1; pend_a = req_addr; pend_v = nv; end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() != 0 && expq[0].due == cyc) begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_data", rsp_data, expq[0].d);
                chk("rsp_err", rsp_err, expq[0].e);
                void'(expq.pop_front());
            end else chk("rsp_quiet", rsp_valid, 0);
            chk("req_ready", req_ready, m_ready(cyc));
            chk("busy", busy, !m_ready(cyc));
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        req_valid = 1; req_op = op; req_addr = a; req_data = d;
        for (int i = 0; i < DEPTH + 20; i++) begin
            tick();
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        req_valid = 0;
    endtask

    task automatic op_chk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] ed, input logic ee, input string n);
        issue(op, a, d);
        if (op != 2'b01) begin
            chk({n, "_ready_lo"}, req_ready, 0);
            tick();
            chk({n, "_ready_hi"}, req_ready, 1);
        end
        chk({n, "_valid"}, rsp_valid, 1);
        chk({n, "_data"}, rsp_data, ed);
        chk({n, "_err"}, rsp_err, ee);
    endtask

    initial begin
        int n;
        tick();
        chk_en = 1;
        tick(); tick();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
        chk("rst_busy", busy, 1);
`else
        chk("rst_ready", req_ready, 1);
`endif
        reset = 0;
        for (int a = 0; a < DEPTH; a++) issue(2'b01, 8'(a), 8'($urandom));

        op_chk(2'b01, 8'h06, 8'h33, 8'h33, 0, "wr06");
        op_chk(2'b00, 8'h06, 8'h00, 8'h33, 0, "rd06");
        op_chk(2'b01, 8'h06, 8'hFF, 8'hFF, 0, "wr06_ff");
        op_chk(2'b10, 8'h06, 8'h01, 8'h00, 0, "add_wrap");
        op_chk(2'b00, 8'h06, 8'h00, 8'h00, 0, "rd_after_add");
        op_chk(2'b01, 8'h0A, 8'h3C, 8'h3C, 0, "wr0a");
        op_chk(2'b11, 8'h0A, 8'hA5, 8'h3C, 0, "swap_old");
        op_chk(2'b00, 8'h0A, 8'h00, 8'hA5, 0, "rd_after_swap");
        for (int i = 0; i < 4; i++) op_chk(2'b01, 8'(i), 8'(8'h11 * (i + 1)), 8'(8'h11 * (i + 1)), 0, "wr_b2b");
        for (int i = 0; i < 4; i++) op_chk(2'b00, 8'(i), 8'h00, 8'(8'h11 * (i + 1)), 0, "rd_b2b");
        op_chk(2'b00, 8'hC8, 8'h00, 8'h00, 1, "oor_rd");
        op_chk(2'b01, 8'hFF, 8'h77, 8'h00, 1, "oor_wr");
        op_chk(2'b10, 8'hC9, 8'h01, 8'h00, 1, "oor_add");

        op_chk(2'b01, 8'h05, 8'h05, 8'h05, 0, "wr05");
        issue(2'b10, 8'h05, 8'h01);
        reset = 1;
        tick();
        chk("rst_abandon", rsp_valid, 0);
        reset = 0;
`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
        op_chk(2'b00, 8'h05, 8'h00, 8'h00, 0, "rst_rd05");
`else
        op_chk(2'b00, 8'h05, 8'h00, 8'h05, 0, "rst_rd05");
`endif

        repeat (3000) begin
            req_valid = $urandom_range(0, 9) < 7;
            req_op = 2'($urandom);
            req_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1));
            req_data = 8'($urandom);
            reset = $urandom_range(0, 399) == 0;
            tick();
        end
        req_valid = 0;
        reset = 0;
        repeat (DEPTH + 4) tick();

`ifdef RAM_RMW_CTRL_MEM_CLEAR_EN
        reset = 1;
        tick();
        reset = 0;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        chk("clear_cycles", n, 16);
        op_chk(2'b00, 8'h07, 8'h00, 8'h00, 0, "clr_rd07");
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ram_rmw_ctrl.md
Name: ram_rmw_ctrl

Overview:
- Parametrised single-port memory controller: a synchronous RAM array plus an FSM that runs one request at a time.
- Supports READ, WRITE, ADD (read-modify-write increment) and SWAP behind a valid/ready request handshake and a registered one-cycle response pulse.
- Sits between the processor datapath/ALU and data memory.
- Generalises the fixed 8-bit read-then-write RAM exercise into a reusable, width/depth-parametrised block.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 2**ADDR_W, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  2  00 READ, 01 WRITE, 10 ADD, 11 SWAP.
- req_addr  in  ADDR_W  word address.
- req_data  in  DATA_W  write data, addend, or swap value.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  response data.
- rsp_err  out  1  with rsp_valid: address >= DEPTH.
- busy  out  1  equals ~req_ready.

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, rsp_err=0; req_ready=1 (see optional feature); FSM to IDLE.
  - Memory contents are not reset.
  - Reset mid-operation abandons the operation; no RAM write occurs in the reset cycle or after it.
- Accept: a request is accepted in cycle c0 when req_valid && req_ready at the rising edge. With req_ready=0, inputs are ignored and have no RAM effect.
- The RAM is driven combinationally from req_* while in IDLE, and from latched request registers otherwise.
- RAM read latency is 1 cycle: q is valid the cycle after its address is sampled.
- FSM states:
  - IDLE: req_ready=1.
    - WRITE accepted: RAM written at the c0 edge; stay IDLE.
    - READ/ADD/SWAP accepted: RAM read at the c0 edge; go to RD_WAIT.
  - RD_WAIT (c1): req_ready=0; q valid.
    - ADD: drive write of (q + data) mod 2**DATA_W; carry discarded.
    - SWAP: drive write of latched data.
    - READ: no write.
    - Always return to IDLE at the c1 edge.
- Response (registered), rsp_valid high for exactly one cycle:
  - WRITE: c1, rsp_data = written data.
  - READ: c2, rsp_data = q.
  - ADD: c2, rsp_data = new (sum) value.
  - SWAP: c2, rsp_data = old value.
- Throughput: WRITE one per cycle; READ/ADD/SWAP one per two cycles (req_ready low in c1 only).
- A new request accepted in c2 overlaps the previous response; ordering is preserved.
- Out of range (addr >= DEPTH): no write; rsp_data=0, rsp_err=1, same latency as the op.
- Back-to-back WRITE then READ of the same address returns the newly written value.

Optional Feature:
- Macro RAM_RMW_CTRL_MEM_CLEAR_EN.
- Defined: after reset, FSM enters CLEAR and writes 0 to addresses 0..DEPTH-1, one per cycle.
  - req_ready=0 and busy=1 for exactly DEPTH cycles, then IDLE.
  - Reset during CLEAR restarts the clear from address 0.
- Undefined: no CLEAR state; req_ready=1 in the first cycle after reset; memory power-up contents are undefined.

Decomposition:
- Package ram_rmw_pkg: op_e enum (OP_READ, OP_WRITE, OP_ADD, OP_SWAP), state_e enum (IDLE, RD_WAIT, CLEAR), op encoding constants.
- Sub-module sync_ram_sp: DATA_W/DEPTH-parametrised single-port RAM with ports clock, addr, wdata, wen, q and 1-cycle registered read.
- The controller instantiates sync_ram_sp once.

Test Plan:
- WRITE addr 0x26 data 0x33 -> rsp_valid in c1 with rsp_data 0x33; READ 0x26 -> rsp_valid in c2 with rsp_data 0x33; req_ready low exactly one cycle.
- ADD addr 0x26 data 0x01 on stored 0xFF -> rsp_data 0x00 (wrap), subsequent READ returns 0x00.
- SWAP addr 0x10 data 0xA5 on stored 0x3C -> rsp_data 0x3C, subsequent READ returns 0xA5.
- Four WRITEs on consecutive cycles (0x00..0x03 data 0x11..0x44) -> four rsp pulses c1..c4, then all four read back correctly.
- reset asserted during RD_WAIT of ADD on stored 0x05 -> no rsp_valid, READ afterwards returns 0x05; with DEPTH=200 READ 0xC8 -> rsp_err=1, rsp_data=0.
- MEM_CLEAR_EN build, DEPTH=16: reset -> busy high exactly 16 cycles; READ any address returns 0x00.
